// File: rtl/seq_issue.sv
// seq_issue: in-order issue sequencer for a four-register ALU datapath.
// One instruction in flight; results come back combinationally or after a wait.
module seq_issue #(
  parameter int alu_width      = 8,
  parameter int seq_op_width   = 2,
  parameter int seq_im_width   = 4,
  parameter int timeout_cycles = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              i_inst,
  input  logic                    i_inst_valid,
  output logic                    o_inst_ready,
  output logic [alu_width-1:0]    o_alu_data_a,
  output logic [alu_width-1:0]    o_alu_data_b,
  output logic [seq_op_width-1:0] o_alu_op,
  output logic [seq_im_width-1:0] o_alu_const,
  output logic                    o_alu_valid,
  input  logic [alu_width-1:0]    i_alu_data,
  input  logic                    i_alu_valid,
  output logic [alu_width-1:0]    o_send_data,
  output logic                    o_send_valid,
  output logic                    o_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [1:0] OP_PUSH = 2'd0;
  localparam logic [1:0] OP_SEND = 2'd3;
  localparam logic [7:0] TMO     = 8'(timeout_cycles);

  state_t               state;
  logic [7:0]           inst_q;
  logic [7:0]           cnt;
  logic [alu_width-1:0] regs [4];

  logic [1:0] in_op;
  logic [1:0] in_ra;
  logic [1:0] in_rb;
  logic [1:0] in_rd;
  logic [1:0] q_op;
  logic [1:0] wb_rd;
  logic       unused_bits;

  assign in_op = i_inst[7:6];
  assign in_ra = i_inst[5:4];
  assign in_rb = i_inst[3:2];
  assign in_rd = i_inst[1:0];

  // push names its target in [5:4], add/multi in [1:0]
  assign q_op  = inst_q[7:6];
  assign wb_rd = (q_op == OP_PUSH) ? inst_q[5:4] : inst_q[1:0];

  assign unused_bits = ^inst_q[3:2];

  assign o_inst_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      inst_q       <= '0;
      cnt          <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      o_alu_data_a <= '0;
      o_alu_data_b <= '0;
      o_alu_op     <= '0;
      o_alu_const  <= '0;
      o_alu_valid  <= 1'b0;
      o_send_data  <= '0;
      o_send_valid <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_alu_valid  <= 1'b0;
      o_send_valid <= 1'b0;
      o_err        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_inst_valid) begin
            inst_q <= i_inst;
            state  <= ISSUE;
            // operands are captured here, so writeback never disturbs them
            unique case (1'b1)
              (in_op == OP_SEND): begin
                o_send_valid <= 1'b1;
                o_send_data  <= regs[in_ra];
              end
              (in_op == OP_PUSH): begin
                o_alu_valid  <= 1'b1;
                o_alu_op     <= seq_op_width'(in_op);
                o_alu_data_a <= regs[in_ra];
                o_alu_data_b <= '0;
                o_alu_const  <= seq_im_width'(i_inst[3:0]);
              end
              default: begin
                o_alu_valid  <= 1'b1;
                o_alu_op     <= seq_op_width'(in_op);
                o_alu_data_a <= regs[in_ra];
                o_alu_data_b <= regs[in_rb];
                o_alu_const  <= '0;
              end
            endcase
          end
        end
        ISSUE: begin
          if (q_op == OP_SEND) begin
            state <= IDLE;
          end else if (i_alu_valid) begin
            regs[wb_rd] <= i_alu_data;
            state       <= IDLE;
          end else begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (i_alu_valid) begin
            regs[wb_rd] <= i_alu_data;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt + 8'd1 == TMO) begin
              o_err <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
